// File: rtl/quad_enc_pkg.sv
// Shared types and the Gray-code step decoder for the quadrature encoder block.
//   ab_t   : filtered {A,B} channel pair
//   dir_e  : step direction (CW = +1, CCW = -1)
//   qdec() : classifies an old->new {A,B} change as idle, legal step or illegal jump
package quad_enc_pkg;

  typedef logic [1:0] ab_t;

  typedef enum logic {
    DIR_CW  = 1'b0,
    DIR_CCW = 1'b1
  } dir_e;

  typedef struct packed {
    logic valid;
    dir_e dir;
    logic illegal;
  } qdec_t;

  // CW order is 00->10->11->01->00. When A flips, the move is CW iff the new
  // A and B differ; when B flips, it is CW iff they become equal.
  function automatic qdec_t qdec(ab_t old_ab, ab_t new_ab);
    qdec_t res;
    ab_t   chg;
    chg         = old_ab ^ new_ab;
    res.valid   = 1'b0;
    res.dir     = DIR_CW;
    res.illegal = 1'b0;
    case (chg)
      2'b00:   ;
      2'b11:   res.illegal = 1'b1;
      default: begin
        res.valid = 1'b1;
        res.dir   = dir_e'(new_ab[1] ^ new_ab[0] ^ chg[1]);
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// One encoder channel: multi-flop synchroniser followed by a persistence filter.
// A level change is accepted only after FILT_CYCLES consecutive synchronised samples
// differ from the current filtered level.
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset (filtered level loads the synchronised pin)
//   din      : raw asynchronous channel input
//   sample_o : last synchroniser stage
//   filt_o   : filtered channel level
module quad_glitch_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sample_o,
  output logic filt_o
);

  localparam int unsigned    CntW    = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FILT_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   filt_q, filt_d;
  logic [CntW-1:0]        fcnt_q, fcnt_d;

  assign sample_o = sync_q[SYNC_STAGES-1];
  assign filt_o   = filt_q;

  // Synchroniser flops are deliberately not reset.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    if (sample_o == filt_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == CntLast) begin
      filt_d = sample_o;
      fcnt_d = '0;
    end else begin
      fcnt_d = fcnt_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Track the pin during reset so release never looks like a transition.
      filt_q <= sample_o;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

endmodule

// File: rtl/quad_enc_decoder.sv
// Quadrature encoder decoder: synchronises and glitch-filters A/B, x4-decodes each
// legal Gray transition into a +/-1 step on a signed position counter, and flags
// simultaneous A/B changes as a sticky error.
// Ports:
//   clk     : system clock
//   rst     : synchronous active-high reset
//   a, b    : asynchronous encoder channels
//   clr     : synchronous clear of cnt_o (wins over a coincident step)
//   err_clr : clears err_o (a coincident illegal event wins)
//   cnt_o   : signed position, wraps (WRAP=1) or saturates (WRAP=0)
//   step_o  : one-cycle pulse per legal step
//   dir_o   : direction of last legal step, 0 = CW (+1), 1 = CCW (-1)
//   err_o   : sticky illegal-transition flag
module quad_enc_decoder
  import quad_enc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 16,
  parameter int unsigned CNT_W       = 16,
  parameter bit          WRAP        = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  input  logic             err_clr,
  output logic [CNT_W-1:0] cnt_o,
  output logic             step_o,
  output logic             dir_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] CntMax = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CntMin = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic   samp_a, samp_b, filt_a, filt_b;
  ab_t    ab_q, ab_new;
  qdec_t  dec;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  dir_e             dir_q, dir_d;
  logic             err_q, err_d;

  quad_glitch_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_CYCLES(FILT_CYCLES)
  ) u_filt_a (
    .clk     (clk),
    .rst     (rst),
    .din     (a),
    .sample_o(samp_a),
    .filt_o  (filt_a)
  );

  quad_glitch_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_CYCLES(FILT_CYCLES)
  ) u_filt_b (
    .clk     (clk),
    .rst     (rst),
    .din     (b),
    .sample_o(samp_b),
    .filt_o  (filt_b)
  );

  assign ab_new = {filt_a, filt_b};
  assign dec    = qdec(ab_q, ab_new);

  always_comb begin
    cnt_d  = cnt_q;
    step_d = 1'b0;
    dir_d  = dir_q;
    err_d  = err_q;

    if (dec.valid) begin
      step_d = 1'b1;
      dir_d  = dec.dir;
      if (dec.dir == DIR_CW) begin
        cnt_d = (!WRAP && cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
      end else begin
        cnt_d = (!WRAP && cnt_q == CntMin) ? cnt_q : cnt_q - CntOne;
      end
    end

    if (clr) begin
      cnt_d = '0;
    end

    if (dec.illegal) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Load from the same synchroniser stage the filters load from, so the
      // decoder's old state equals the filtered state at release.
      ab_q   <= {samp_a, samp_b};
      cnt_q  <= '0;
      step_q <= 1'b0;
      dir_q  <= DIR_CW;
      err_q  <= 1'b0;
    end else begin
      ab_q   <= ab_new;
      cnt_q  <= cnt_d;
      step_q <= step_d;
      dir_q  <= dir_d;
      err_q  <= err_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign step_o = step_q;
  assign dir_o  = dir_q;
  assign err_o  = err_q;

endmodule
